// File: rtl/bsg_halfpod_link_bringup_seq_if.sv
// Control and status bundle of the halfpod link bring-up sequencer.
// The master side (tag-client logic or bench) drives requests and configuration.
// The slave side (the sequencer) drives the SDR reset and disable controls.
// When BSG_HALFPOD_LINK_SEQ_STATUS_EN is defined, phase and abort-count status are added.
interface bsg_halfpod_link_bringup_seq_if #(
    parameter int num_links_p    = 3,
    parameter int hold_width_p   = 8,
    parameter int y_cord_width_p = 7
);
    logic                      start_i;
    logic                      abort_i;
    logic [num_links_p-1:0]    link_en_i;
    logic [hold_width_p-1:0]   hold_cycles_i;
    logic [y_cord_width_p-1:0] global_y_cord_i;

    logic [y_cord_width_p-1:0] global_y_cord_o;
    logic [num_links_p-1:0]    link_disable_o;
    logic [num_links_p-1:0]    token_reset_o;
    logic [num_links_p-1:0]    uplink_reset_o;
    logic [num_links_p-1:0]    downlink_reset_o;
    logic [num_links_p-1:0]    downstream_reset_o;
    logic                      core_reset_o;
    logic                      busy_o;
    logic                      done_o;
`ifdef BSG_HALFPOD_LINK_SEQ_STATUS_EN
    logic [2:0]                phase_o;
    logic [7:0]                abort_count_o;
`endif

    modport master (
        output start_i, abort_i, link_en_i, hold_cycles_i, global_y_cord_i,
        input  global_y_cord_o, link_disable_o, token_reset_o, uplink_reset_o,
               downlink_reset_o, downstream_reset_o, core_reset_o, busy_o, done_o
`ifdef BSG_HALFPOD_LINK_SEQ_STATUS_EN
        , input phase_o, abort_count_o
`endif
    );

    modport slave (
        input  start_i, abort_i, link_en_i, hold_cycles_i, global_y_cord_i,
        output global_y_cord_o, link_disable_o, token_reset_o, uplink_reset_o,
               downlink_reset_o, downstream_reset_o, core_reset_o, busy_o, done_o
`ifdef BSG_HALFPOD_LINK_SEQ_STATUS_EN
        , output phase_o, abort_count_o
`endif
    );
endinterface

// File: rtl/bsg_halfpod_link_bringup_seq.sv
// Ordered, timed reset/bring-up sequencer for the halfpod SDR links.
// Sequence: ENABLE, TOKEN, UPLINK, DOWNLINK, DOWNSTREAM, CORE, each lasting H+1 cycles,
// and then DONE. Only links in the mask latched at start are released.
// All outputs come straight from registers, so no input has a combinational path to an output.
// Optional status outputs (phase, abort count) are built when BSG_HALFPOD_LINK_SEQ_STATUS_EN is defined.
module bsg_halfpod_link_bringup_seq #(
    parameter int num_links_p    = 3,
    parameter int hold_width_p   = 8,
    parameter int y_cord_width_p = 7
) (
    input logic clk_i,
    input logic reset_i,
    bsg_halfpod_link_bringup_seq_if.slave bus
);
    // Encoding doubles as the externally visible phase number.
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ENABLE     = 3'd1,
        TOKEN      = 3'd2,
        UPLINK     = 3'd3,
        DOWNLINK   = 3'd4,
        DOWNSTREAM = 3'd5,
        CORE       = 3'd6,
        DONE       = 3'd7
    } state_e;

    localparam logic [hold_width_p-1:0] hold_one_lp = hold_width_p'(1);

    state_e                    state_r, state_s;
    logic [hold_width_p-1:0]   cnt_r, cnt_s;
    logic [hold_width_p-1:0]   hold_r, hold_s;
    logic [num_links_p-1:0]    mask_r, mask_s;
    logic [y_cord_width_p-1:0] y_r, y_s;

    logic [num_links_p-1:0]    link_disable_r, link_disable_s;
    logic [num_links_p-1:0]    token_reset_r, token_reset_s;
    logic [num_links_p-1:0]    uplink_reset_r, uplink_reset_s;
    logic [num_links_p-1:0]    downlink_reset_r, downlink_reset_s;
    logic [num_links_p-1:0]    downstream_reset_r, downstream_reset_s;
    logic                      core_reset_r, core_reset_s;
    logic                      busy_r, busy_s;
    logic                      done_r, done_s;
    logic [2:0]                phase_s;

    // Next-state logic: abort overrides everything; phases advance when the hold counter reads 0.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        hold_s  = hold_r;
        mask_s  = mask_r;
        y_s     = y_r;
        if (bus.abort_i) begin
            state_s = IDLE;
            cnt_s   = '0;
            hold_s  = '0;
            mask_s  = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start_i && (bus.link_en_i != '0)) begin
                        state_s = ENABLE;
                        cnt_s   = bus.hold_cycles_i;
                        hold_s  = bus.hold_cycles_i;
                        mask_s  = bus.link_en_i;
                        y_s     = bus.global_y_cord_i;
                    end else begin
                        state_s = IDLE;
                    end
                end
                ENABLE, TOKEN, UPLINK, DOWNLINK, DOWNSTREAM, CORE: begin
                    if (cnt_r == '0) begin
                        // CORE + 1 is DONE, so a simple increment walks the sequence.
                        state_s = state_e'(state_r + 3'd1);
                        cnt_s   = hold_r;
                    end else begin
                        cnt_s   = cnt_r - hold_one_lp;
                    end
                end
                DONE: begin
                    state_s = DONE;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // Output decode from the next state so that the output registers line up with the state register.
    always_comb begin
        phase_s            = state_s;
        link_disable_s     = (phase_s >= 3'd1) ? ~mask_s : '1;
        token_reset_s      = (phase_s == 3'd2) ?  mask_s : '0;
        uplink_reset_s     = (phase_s >= 3'd3) ? ~mask_s : '1;
        downlink_reset_s   = (phase_s >= 3'd4) ? ~mask_s : '1;
        downstream_reset_s = (phase_s >= 3'd5) ? ~mask_s : '1;
        core_reset_s       = (phase_s < 3'd6);
        busy_s             = (phase_s >= 3'd1) && (phase_s <= 3'd6);
        done_s             = (phase_s == 3'd7);
    end

    // State, latched configuration and output registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r            <= IDLE;
            cnt_r              <= '0;
            hold_r             <= '0;
            mask_r             <= '0;
            y_r                <= '0;
            link_disable_r     <= '1;
            token_reset_r      <= '0;
            uplink_reset_r     <= '1;
            downlink_reset_r   <= '1;
            downstream_reset_r <= '1;
            core_reset_r       <= 1'b1;
            busy_r             <= 1'b0;
            done_r             <= 1'b0;
        end else begin
            state_r            <= state_s;
            cnt_r              <= cnt_s;
            hold_r             <= hold_s;
            mask_r             <= mask_s;
            y_r                <= y_s;
            link_disable_r     <= link_disable_s;
            token_reset_r      <= token_reset_s;
            uplink_reset_r     <= uplink_reset_s;
            downlink_reset_r   <= downlink_reset_s;
            downstream_reset_r <= downstream_reset_s;
            core_reset_r       <= core_reset_s;
            busy_r             <= busy_s;
            done_r             <= done_s;
        end
    end

    assign bus.global_y_cord_o    = y_r;
    assign bus.link_disable_o     = link_disable_r;
    assign bus.token_reset_o      = token_reset_r;
    assign bus.uplink_reset_o     = uplink_reset_r;
    assign bus.downlink_reset_o   = downlink_reset_r;
    assign bus.downstream_reset_o = downstream_reset_r;
    assign bus.core_reset_o       = core_reset_r;
    assign bus.busy_o             = busy_r;
    assign bus.done_o             = done_r;

`ifdef BSG_HALFPOD_LINK_SEQ_STATUS_EN
    logic [7:0] abort_count_r;

    // Saturating count of aborts that interrupt a running sequence; only reset clears it.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            abort_count_r <= 8'd0;
        end else if (bus.abort_i && busy_r && (abort_count_r != 8'd255)) begin
            abort_count_r <= abort_count_r + 8'd1;
        end else begin
            abort_count_r <= abort_count_r;
        end
    end

    assign bus.phase_o       = state_r;
    assign bus.abort_count_o = abort_count_r;
`endif
endmodule

// File: tb/tb_bsg_halfpod_link_bringup_seq.sv
// Scoreboard bench for the halfpod link bring-up sequencer.
// The reference model tracks only "cycles since start" and derives the phase arithmetically;
// expected outputs are queued at each clock edge and checked by a monitor on the falling edge.
module tb_bsg_halfpod_link_bringup_seq;
    localparam int NL = 3;
    localparam int HW = 8;
    localparam int YW = 7;

    logic clk;
    logic reset;

    bsg_halfpod_link_bringup_seq_if #(.num_links_p(NL), .hold_width_p(HW), .y_cord_width_p(YW)) bus ();

    bsg_halfpod_link_bringup_seq #(.num_links_p(NL), .hold_width_p(HW), .y_cord_width_p(YW)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef logic [YW+5*NL+2:0] vec_t;

    vec_t q_vec[$];
    int   q_phase[$];
    int   q_abcnt[$];

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    // Reference model state
    bit          m_active = 1'b0;
    int          m_elapsed = 0;
    logic [NL-1:0] m_mask = '0;
    int          m_h = 0;
    logic [YW-1:0] m_y = '0;
    int          m_abcnt = 0;

    // Phase number: 0 idle, 1..6 the timed phases, 7 done.
    function automatic int cur_phase();
        int k;
        if (!m_active) return 0;
        k = m_elapsed / (m_h + 1);
        if (k >= 6) return 7;
        return k + 1;
    endfunction

    function automatic vec_t expect_vec(int p, logic [NL-1:0] mk, logic [YW-1:0] y);
        logic [NL-1:0] dis, tok, up, dn, ds;
        logic core, busy, done;
        dis  = (p >= 1) ? ~mk : {NL{1'b1}};
        tok  = (p == 2) ?  mk : {NL{1'b0}};
        up   = (p >= 3) ? ~mk : {NL{1'b1}};
        dn   = (p >= 4) ? ~mk : {NL{1'b1}};
        ds   = (p >= 5) ? ~mk : {NL{1'b1}};
        core = (p < 6);
        busy = (p >= 1) && (p <= 6);
        done = (p == 7);
        return {y, dis, tok, up, dn, ds, core, busy, done};
    endfunction

    // Advance the model over one clock edge using the inputs that edge sampled.
    task automatic model_step();
        int p;
        p = cur_phase();
        if (reset) begin
            m_active = 1'b0; m_mask = '0; m_h = 0; m_y = '0; m_abcnt = 0;
        end else if (bus.abort_i) begin
            if (p >= 1 && p <= 6 && m_abcnt < 255) m_abcnt++;
            m_active = 1'b0; m_mask = '0;
        end else if (!m_active && bus.start_i && (bus.link_en_i != '0)) begin
            m_active = 1'b1; m_elapsed = 0;
            m_mask = bus.link_en_i; m_h = int'(bus.hold_cycles_i); m_y = bus.global_y_cord_i;
        end else if (m_active) begin
            m_elapsed++;
        end
        q_vec.push_back(expect_vec(cur_phase(), m_mask, m_y));
        q_phase.push_back(cur_phase());
        q_abcnt.push_back(m_abcnt);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
    endtask

    task automatic drive(bit st, bit ab, logic [NL-1:0] en, logic [HW-1:0] h, logic [YW-1:0] y);
        bus.start_i = st; bus.abort_i = ab; bus.link_en_i = en;
        bus.hold_cycles_i = h; bus.global_y_cord_i = y;
        tick();
    endtask

    task automatic idle(int n);
        bus.start_i = 1'b0; bus.abort_i = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Monitor: every cycle the DUT presents a full output set; compare it to the next expectation.
    always @(negedge clk) begin
        vec_t exp_v, act_v;
        int   exp_p, exp_a;
        if (q_vec.size() > 0) begin
            exp_v = q_vec.pop_front();
            exp_p = q_phase.pop_front();
            exp_a = q_abcnt.pop_front();
            act_v = {bus.global_y_cord_o, bus.link_disable_o, bus.token_reset_o, bus.uplink_reset_o,
                     bus.downlink_reset_o, bus.downstream_reset_o, bus.core_reset_o, bus.busy_o, bus.done_o};
            vectors++;
            if (act_v !== exp_v) begin
                miscompares++;
                $display("FAIL outputs cycle %0d: got %h expected %h (y,dis,tok,up,dn,ds,core,busy,done)", cyc, act_v, exp_v);
            end
`ifdef BSG_HALFPOD_LINK_SEQ_STATUS_EN
            vectors++;
            if ((int'(bus.phase_o) != exp_p) || (int'(bus.abort_count_o) != exp_a)) begin
                miscompares++;
                $display("FAIL status cycle %0d: got phase %0d aborts %0d expected phase %0d aborts %0d",
                         cyc, bus.phase_o, bus.abort_count_o, exp_p, exp_a);
            end
`endif
        end
    end

    initial begin
        int budget;
        bus.start_i = 1'b0; bus.abort_i = 1'b0; bus.link_en_i = '0;
        bus.hold_cycles_i = '0; bus.global_y_cord_i = '0;
        reset = 1'b1;
        tick(); tick(); tick();
        reset = 1'b0;
        idle(10);

        // All links, H=0
        idle(5);
        drive(1'b1, 1'b0, 3'b111, 8'd0, 7'h11);
        idle(15);
        drive(1'b0, 1'b1, 3'b000, 8'd0, 7'h00);   // abort from DONE

        // One link, H=2
        drive(1'b1, 1'b0, 3'b010, 8'd2, 7'h05);
        idle(22);
        drive(1'b0, 1'b1, 3'b000, 8'd0, 7'h00);

        // Empty mask is ignored; next start proceeds
        drive(1'b1, 1'b0, 3'b000, 8'd1, 7'h33);
        idle(3);
        drive(1'b1, 1'b0, 3'b001, 8'd1, 7'h34);
        idle(16);
        drive(1'b1, 1'b0, 3'b111, 8'd0, 7'h00);   // start in DONE ignored
        idle(2);
        drive(1'b0, 1'b1, 3'b000, 8'd0, 7'h00);

        // Abort during DOWNLINK with start also high, then re-run
        drive(1'b1, 1'b0, 3'b111, 8'd1, 7'h21);
        idle(7);
        drive(1'b1, 1'b1, 3'b101, 8'd0, 7'h7F);
        idle(3);
        drive(1'b1, 1'b0, 3'b101, 8'd1, 7'h22);
        idle(16);
        drive(1'b0, 1'b1, 3'b000, 8'd0, 7'h00);

        // Maximum hold; coordinate and config change mid-sequence
        drive(1'b1, 1'b0, 3'b011, 8'd255, 7'h2A);
        for (int i = 0; i < 6 * 256 + 4; i++)
            drive(1'($urandom_range(0, 1)), 1'b0, NL'($urandom), HW'($urandom), YW'($urandom));
        drive(1'b0, 1'b1, 3'b000, 8'd0, 7'h00);

        // Randomized traffic with occasional aborts and resets
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0),
                  NL'($urandom), HW'($urandom_range(0, 3)), YW'($urandom));
        end
        reset = 1'b0;
        idle(30);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle(2);

        budget = 0;
        while (q_vec.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        if (q_vec.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", q_vec.size());
        end
        #20;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
